regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file for the pipelined RISC-V core, successor to the fixed 2-read/1-write file. It adds a configurable number of read ports, a hardwired-zero x0, an asynchronous clear, and a per-register busy scoreboard used by the decode stage for hazard detection. Optionally, it provides same-cycle write-to-read bypass. It sits between decode (reads, reservations) and writeback (writes, releases).

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of architectural registers (power of two, ≥ 2)
- `NRD`, 2, number of read ports (1–4)
- `AW`, `$clog2(NREGS)`, address width (derived; not overridden)

- `clk` in 1: single clock, all state updates on its rising edge
- `rst` in 1: asynchronous, active-low reset
- `rd_addr` in NRD*AW: read addresses, port i at bits [i*AW +: AW]
- `rd_data` out NRD*XLEN: read data, port i at bits [i*XLEN +: XLEN]
- `rd_busy` out NRD: register at port i has an outstanding reservation
- `we` in 1: write enable (writeback)
- `wa` in AW: write address
- `wd` in XLEN: write data
- `rsv_en` in 1: reserve destination (issue of a writing instruction)
- `rsv_addr` in AW: register to mark busy
- `flush` in 1: clear all busy bits (pipeline flush)
- `busy_vec` out NREGS: full scoreboard, bit n = register n busy

## Operation
- Storage: NREGS × XLEN array plus NREGS busy bits. Register 0 has no storage: it reads as 0 and is never busy.
- Reset (`rst`=0): all registers and busy bits are cleared immediately, independent of the clock. While `rst`=0, `rd_data`=0, `rd_busy`=0 and `busy_vec`=0.
- Read: combinational from `rd_addr`; no clock latency.
- Write: on rising `clk` with `we`=1 and `wa`≠0, `registers[wa]` ← `wd` and `busy[wa]` ← 0. A write to x0 is discarded.
- Reserve: on rising `clk` with `rsv_en`=1 and `rsv_addr`≠0, `busy[rsv_addr]` ← 1.
- Simultaneous events on one edge, in priority order:
  - `flush`=1: all busy bits cleared; `rsv_en` is ignored. The pending write still commits.
  - `we` and `rsv_en` to the same address: data is written and busy ends at 1 (the new reservation wins).
  - `we` and `rsv_en` to different addresses: both take effect independently.
- Multiple read ports may address the same register; each returns identical values.
- Releasing a register that is not busy is legal; it has no effect on busy.

## Timing
- Read data and `rd_busy` are valid in the same cycle the address is applied.
- A written value is visible on reads in the cycle after the write edge. With bypass enabled, it is visible in the same cycle (see Configuration).
- A reservation is visible on `rd_busy`/`busy_vec` in the cycle after the `rsv_en` edge.
- Reset assertion takes effect asynchronously. Deassertion is synchronised externally; the first update occurs on the first edge after release.
- Reset asserted mid-operation discards any in-flight write or reservation on that edge.

## Configuration
- Macro: `REGFILE_SB_BYPASS_EN`.
- Defined: when `we`=1 and `wa`==`rd_addr[i]`≠0, port i returns `wd` and `rd_busy[i]`=0 in the same cycle. This removes the writeback→decode stall.
- Undefined: port i returns the stored value and the stored busy bit. The core must stall one cycle on that hazard.
- `busy_vec` always reflects stored state only, with or without the macro.

## Structure
- Package `regfile_pkg`: defaults for `XLEN`/`NREGS`, a derived `AW` constant, and the `REG_ZERO` address constant.
- One sub-module, `regfile_scoreboard`: the NREGS busy bits with reserve/release/flush logic and `busy_vec` output. The top level holds the data array, the read muxes and the bypass.

## Test plan
- Reset then read: pulse `rst`=0 mid-cycle, all ports read addresses 1/31 → `rd_data`=0x00000000, `busy_vec`=0, without waiting for a clock edge.
- x0 immunity: write 0xDEADBEEF to x0 and reserve x0 → reads of x0 return 0, `busy_vec[0]`=0.
- Write/read: write 0x00000006 to x5 and 0x0000000A to x6, then read ports 0/1 at x5/x6 → 0x6/0xA the next cycle.
- Scoreboard: reserve x7 → `rd_busy`=1 on port reading x7. Write 0x1234 to x7 → busy clears next cycle. Same-edge write and reserve of x7 → busy stays 1 and data = new value.
- Flush: reserve x3 and x4, then `flush` with `rsv_en` to x8 and `we` to x3=0x55 → `busy_vec`=0, x3 reads 0x55.
- Bypass: `we` x9=0xCAFE while port 1 reads x9 → 0xCAFE and busy 0 same cycle with `REGFILE_SB_BYPASS_EN`; old value (0) without it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry,
// the derived address width and the hardwired-zero register address.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int REG_ZERO  = 0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set by a reservation
// at issue, cleared by the writeback release or by a pipeline flush.
// x0 is never busy and has no storage.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
);

    assign busy_vec[REG_ZERO] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_busy
            logic busy_reg;

            // Flush beats everything; a new reservation beats a release of the same register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    busy_reg <= 1'b0;
                end else if (flush) begin
                    busy_reg <= 1'b0;
                end else if (rsv_en && (rsv_addr == AW'(gi))) begin
                    busy_reg <= 1'b1;
                end else if (we && (wa == AW'(gi))) begin
                    busy_reg <= 1'b0;
                end
            end

            assign busy_vec[gi] = busy_reg;
        end
    endgenerate

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, hardwired-zero x0,
// asynchronous active-low clear and a per-register busy scoreboard.
// Optional feature macro: REGFILE_SB_BYPASS_EN -- when defined, a same-cycle
// write to the address a port is reading is forwarded (data = wd, busy = 0).
// busy_vec always shows stored scoreboard state only.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    // Flattened view of the architectural state; entry 0 is the constant zero.
    logic [NREGS-1:0][XLEN-1:0] reg_view;

    assign reg_view[REG_ZERO] = '0;

    genvar gi;
    generate
        // Data storage for x1..x(NREGS-1). Kept in flops because the whole
        // file must clear asynchronously, which block RAM cannot do.
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [XLEN-1:0] data_reg;

            // Commit writeback data; flush does not affect data.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg <= '0;
                end else if (we && (wa == AW'(gi))) begin
                    data_reg <= wd;
                end
            end

            assign reg_view[gi] = data_reg;
        end
    endgenerate

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data_sel;
            logic            busy_sel;

            assign addr = rd_addr[gi*AW +: AW];

            // Read mux, optional writeback forward, and forced zero while reset is held
            // (the gate matters only for the forwarded path; stored state is already clear).
            always_comb begin
                data_sel = reg_view[addr];
                busy_sel = busy_vec[addr];
`ifdef REGFILE_SB_BYPASS_EN
                if (we && (wa == addr) && (addr != AW'(REG_ZERO))) begin
                    data_sel = wd;
                    busy_sel = 1'b0;
                end
`endif
                if (!rst) begin
                    data_sel = '0;
                    busy_sel = 1'b0;
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = data_sel;
            assign rd_busy[gi]              = busy_sel;
        end
    endgenerate

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb (default geometry: 32 x 32 bits, 2 read ports).
// Expected values are hand-computed; the bypass case follows REGFILE_SB_BYPASS_EN.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                flush;
    logic [NREGS-1:0]    busy_vec;

    int n_checks = 0;
    int n_errors = 0;

    regfile_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("check %s: got %h expected %h ok", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    function automatic logic [XLEN-1:0] port_data(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        set_rd(5'd1, 5'd31);
        #3;
        // Held in reset from time zero
        check("rst_rd0",   64'(port_data(0)), 64'h0);
        check("rst_rd1",   64'(port_data(1)), 64'h0);
        check("rst_busy",  64'(busy_vec),     64'h0);
        check("rst_rdbsy", 64'(rd_busy),      64'h0);

        tick();
        rst = 1'b1;
        tick();

        // Populate x1 and x31, reserve x31, then pulse reset mid-cycle
        we = 1'b1; wa = 5'd1; wd = 32'h1111_1111;
        tick();
        wa = 5'd31; wd = 32'h3131_3131; rsv_en = 1'b1; rsv_addr = 5'd31;
        tick();
        idle();
        #1;
        check("pre_rst_x1",   64'(port_data(0)), 64'h1111_1111);
        check("pre_rst_x31",  64'(port_data(1)), 64'h3131_3131);
        check("pre_rst_busy", 64'(busy_vec),     64'h8000_0000);
        rst = 1'b0;
        #1;
        check("async_rst_x1",   64'(port_data(0)), 64'h0);
        check("async_rst_x31",  64'(port_data(1)), 64'h0);
        check("async_rst_busy", 64'(busy_vec),     64'h0);
        #1;
        rst = 1'b1;
        tick();
        check("post_rst_x31", 64'(port_data(1)), 64'h0);

        // x0 immunity
        we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF; rsv_en = 1'b1; rsv_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        tick();
        idle();
        #1;
        check("x0_rd0",  64'(port_data(0)), 64'h0);
        check("x0_rd1",  64'(port_data(1)), 64'h0);
        check("x0_busy", 64'(busy_vec),     64'h0);

        // Plain writes, visible next cycle
        we = 1'b1; wa = 5'd5; wd = 32'h0000_0006;
        tick();
        wa = 5'd6; wd = 32'h0000_000A;
        tick();
        idle();
        set_rd(5'd5, 5'd6);
        #1;
        check("wr_x5", 64'(port_data(0)), 64'h6);
        check("wr_x6", 64'(port_data(1)), 64'hA);

        // Scoreboard: reserve, release, same-edge write+reserve
        rsv_en = 1'b1; rsv_addr = 5'd7;
        set_rd(5'd7, 5'd7);
        tick();
        idle();
        #1;
        check("rsv_x7_busy", 64'(rd_busy), 64'h3);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_1234;
        tick();
        idle();
        #1;
        check("rel_x7_busy", 64'(rd_busy),      64'h0);
        check("rel_x7_data", 64'(port_data(0)), 64'h1234);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_5678; rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle();
        #1;
        check("wrsv_x7_busy",  64'(rd_busy),      64'h3);
        check("wrsv_x7_data0", 64'(port_data(0)), 64'h5678);
        check("wrsv_x7_data1", 64'(port_data(1)), 64'h5678);

        // Write and reserve of different registers on one edge
        we = 1'b1; wa = 5'd10; wd = 32'h0000_0001; rsv_en = 1'b1; rsv_addr = 5'd11;
        tick();
        idle();
        set_rd(5'd10, 5'd11);
        #1;
        check("split_x10_data", 64'(port_data(0)), 64'h1);
        check("split_rdbusy",   64'(rd_busy),      64'h2);

        // Flush: clears everything, ignores the reservation, write still commits
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        rsv_addr = 5'd4;
        tick();
        idle();
        #1;
        check("pre_flush_busy", 64'(busy_vec), 64'h0000_0898);
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd8;
        we = 1'b1; wa = 5'd3; wd = 32'h0000_0055;
        tick();
        idle();
        set_rd(5'd3, 5'd8);
        #1;
        check("flush_busy", 64'(busy_vec),     64'h0);
        check("flush_x3",   64'(port_data(0)), 64'h55);

        // Same-cycle write to a reserved register being read on port 1
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        we = 1'b1; wa = 5'd9; wd = 32'h0000_CAFE;
        set_rd(5'd0, 5'd9);
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("byp_data",  64'(port_data(1)), 64'hCAFE);
        check("byp_busy",  64'(rd_busy),      64'h0);
`else
        check("byp_data",  64'(port_data(1)), 64'h0);
        check("byp_busy",  64'(rd_busy),      64'h2);
`endif
        check("byp_busyvec", 64'(busy_vec), 64'h0000_0200);
        tick();
        idle();
        #1;
        check("after_byp_data", 64'(port_data(1)), 64'hCAFE);
        check("after_byp_busy", 64'(rd_busy),      64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule : tb_regfile_sb
